// File: rtl/am_mod_pkg.sv
// Shared types, constants and sine-table generator for the AM modulator.
package am_mod_pkg;

  // Carrier quadrant taken from the two phase MSBs.
  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quadrant_e;

  // Edges from an enabled edge to the matching rf_valid, counting that edge.
  localparam int LATENCY       = 4;
  // mod_index is Q1.8: 256 means a depth of 1.0.
  localparam int MOD_FRAC_BITS = 8;

  // Quarter-wave sine entry i of a table with 2^addr_w+1 points, scaled to
  // the largest positive value of an out_w-bit signed sample.
  function automatic int sine_lut_entry(input int i, input int addr_w, input int out_w);
    real amp;
    real ang;
    amp = real'((1 << (out_w - 1)) - 1);
    ang = 1.5707963267948966 * real'(i) / real'(1 << addr_w);
    return $rtoi(amp * $sin(ang) + 0.5);
  endfunction

endpackage

// File: rtl/am_sine_lut.sv
// Registered quarter-wave sine ROM with quadrant mirroring and sign restore.
module am_sine_lut
  import am_mod_pkg::*;
#(
  parameter int LUT_ADDR_WIDTH = 8,
  parameter int OUT_WIDTH      = 12
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [LUT_ADDR_WIDTH+1:0]   phase_msb,
  output logic signed [OUT_WIDTH-1:0] carrier
);

  localparam int DEPTH = (1 << LUT_ADDR_WIDTH) + 1;
  localparam logic [LUT_ADDR_WIDTH:0] FULL_ADDR = (LUT_ADDR_WIDTH + 1)'(1 << LUT_ADDR_WIDTH);

  logic [OUT_WIDTH-1:0] rom [DEPTH];

  // Table contents are elaboration-time constants.
  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    localparam logic [OUT_WIDTH-1:0] ENTRY =
      OUT_WIDTH'(sine_lut_entry(i, LUT_ADDR_WIDTH, OUT_WIDTH));
    assign rom[i] = ENTRY;
  end

  quadrant_e                   quad;
  logic [LUT_ADDR_WIDTH-1:0]   frac;
  logic [LUT_ADDR_WIDTH:0]     addr;
  logic signed [OUT_WIDTH-1:0] mag;
  logic signed [OUT_WIDTH-1:0] carrier_d;
  logic signed [OUT_WIDTH-1:0] carrier_q;

  // Mirror the address in Q1/Q3 (full-scale sits at addr 2^N), negate in Q2/Q3.
  always_comb begin
    quad = quadrant_e'(phase_msb[LUT_ADDR_WIDTH+1 -: 2]);
    frac = phase_msb[LUT_ADDR_WIDTH-1:0];
    addr = {1'b0, frac};
    if (quad == Q1 || quad == Q3) begin
      addr = FULL_ADDR - {1'b0, frac};
    end
    mag       = $signed(rom[addr]);
    carrier_d = (quad == Q2 || quad == Q3) ? -mag : mag;
  end

  // One-cycle registered read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) carrier_q <= '0;
    else        carrier_q <= carrier_d;
  end

  assign carrier = carrier_q;

endmodule

// File: rtl/am_modulator.sv
// AM modulator: rf = env * sin(phase), env = half-scale + mod_index * audio.
// Four-stage pipeline: S1 envelope/phase, S2 sine lookup, S3 multiply, S4 round.
// Audio handshake: a sample transfers on an edge where audio_valid and
// audio_ready are both high; audio_ready is high whenever rst_n is released.
module am_modulator
  import am_mod_pkg::*;
#(
  parameter int AUDIO_WIDTH    = 12,
  parameter int OUT_WIDTH      = 12,
  parameter int PHASE_WIDTH    = 32,
  parameter int LUT_ADDR_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [PHASE_WIDTH-1:0]        phase_inc,
  input  logic [8:0]                    mod_index,
  input  logic signed [AUDIO_WIDTH-1:0] audio_in,
  input  logic                          audio_valid,
  output logic                          audio_ready,
  output logic signed [OUT_WIDTH-1:0]   rf_out,
  output logic                          rf_valid
);

  localparam int PW = AUDIO_WIDTH + 10;             // audio * mod_index
  localparam int EW = AUDIO_WIDTH + 3;              // envelope before clamp
  localparam int RW = AUDIO_WIDTH + OUT_WIDTH + 1;  // env * carrier
  localparam int NM = LUT_ADDR_WIDTH + 2;           // phase bits used by the LUT
  localparam logic signed [EW-1:0] ENV_HALF   = EW'(1 << (AUDIO_WIDTH - 1));
  localparam logic signed [RW-1:0] ROUND_HALF = RW'(1 << (AUDIO_WIDTH - 1));

  logic [PHASE_WIDTH-1:0]        phase_acc_d, phase_acc_q;
  logic signed [AUDIO_WIDTH-1:0] audio_hold_d, audio_hold_q;
  logic [NM-1:0]                 phase_s1_q;
  logic [AUDIO_WIDTH-1:0]        env_s1_d, env_s1_q, env_s2_q;
  logic                          valid_s1_q, valid_s2_q, valid_s3_q;
  logic signed [PW-1:0]          audio_ext, mod_ext, prod, prod_sh;
  logic signed [EW-1:0]          env_raw;
  logic signed [OUT_WIDTH-1:0]   carrier_s2;
  logic signed [RW-1:0]          env_ext, car_ext, mult_s3_d, mult_s3_q, rnd_sum;
  logic signed [OUT_WIDTH-1:0]   rf_out_d, rf_out_q;
  logic                          rf_valid_q;
  logic                          unused_rnd_bits;

  assign audio_ready = rst_n;

  // NCO advance, audio zero-order hold, envelope with clamp to [0, 2^W-1].
  always_comb begin
    phase_acc_d  = enable ? phase_acc_q + phase_inc : phase_acc_q;
    audio_hold_d = (audio_valid && audio_ready) ? audio_in : audio_hold_q;
    audio_ext    = PW'(audio_hold_q);
    mod_ext      = PW'(mod_index);
    prod         = audio_ext * mod_ext;
    prod_sh      = prod >>> MOD_FRAC_BITS;
    env_raw      = EW'(prod_sh) + ENV_HALF;
    if (env_raw[EW-1])                          env_s1_d = '0;
    else if (|env_raw[EW-2:AUDIO_WIDTH])        env_s1_d = '1;
    else                                        env_s1_d = env_raw[AUDIO_WIDTH-1:0];
  end

  // Accumulator, hold register and stage-1 capture (pre-increment phase).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_acc_q  <= '0;
      audio_hold_q <= '0;
      phase_s1_q   <= '0;
      env_s1_q     <= '0;
      valid_s1_q   <= 1'b0;
    end else begin
      phase_acc_q  <= phase_acc_d;
      audio_hold_q <= audio_hold_d;
      phase_s1_q   <= phase_acc_q[PHASE_WIDTH-1 -: NM];
      env_s1_q     <= env_s1_d;
      valid_s1_q   <= enable;
    end
  end

  am_sine_lut #(
    .LUT_ADDR_WIDTH (LUT_ADDR_WIDTH),
    .OUT_WIDTH      (OUT_WIDTH)
  ) u_lut (
    .clk       (clk),
    .rst_n     (rst_n),
    .phase_msb (phase_s1_q),
    .carrier   (carrier_s2)
  );

  // Full-width signed product (env zero-extended) and round-half-up scaling.
  always_comb begin
    env_ext   = RW'({1'b0, env_s2_q});
    car_ext   = RW'(carrier_s2);
    mult_s3_d = env_ext * car_ext;
    rnd_sum   = (mult_s3_q + ROUND_HALF) >>> AUDIO_WIDTH;
    rf_out_d  = valid_s3_q ? rnd_sum[OUT_WIDTH-1:0] : rf_out_q;
  end

  assign unused_rnd_bits = ^rnd_sum[RW-1:OUT_WIDTH];

  // Stages 2-4; rf_out holds its last value while the pipeline is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      env_s2_q   <= '0;
      valid_s2_q <= 1'b0;
      mult_s3_q  <= '0;
      valid_s3_q <= 1'b0;
      rf_out_q   <= '0;
      rf_valid_q <= 1'b0;
    end else begin
      env_s2_q   <= env_s1_q;
      valid_s2_q <= valid_s1_q;
      mult_s3_q  <= mult_s3_d;
      valid_s3_q <= valid_s2_q;
      rf_out_q   <= rf_out_d;
      rf_valid_q <= valid_s3_q;
    end
  end

  assign rf_out   = rf_out_q;
  assign rf_valid = rf_valid_q;

endmodule
